// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - hazard unit control/status bundle
interface pipeline_hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs1;
    logic [4:0]       D_rs2;
    logic [4:0]       E_rs1;
    logic [4:0]       E_rs2;
    logic [4:0]       E_rf_a3;
    logic             E_we_rf;
    logic [1:0]       E_sel_result;
    logic             E_pc_src;
    logic             F_stall;
    logic             D_stall;
    logic             D_flush;
    logic             E_flush;
    logic [1:0]       E_fwd_a;
    logic [1:0]       E_fwd_b;
    logic [4:0]       M_rf_a3;
    logic             M_we_rf;
    logic [4:0]       W_rf_a3;
    logic             W_we_rf;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output D_rs1, D_rs2, E_rs1, E_rs2, E_rf_a3, E_we_rf, E_sel_result, E_pc_src,
        input  F_stall, D_stall, D_flush, E_flush, E_fwd_a, E_fwd_b,
        input  M_rf_a3, M_we_rf, W_rf_a3, W_we_rf, stall_cnt, flush_cnt
    );

    modport slave (
        input  D_rs1, D_rs2, E_rs1, E_rs2, E_rf_a3, E_we_rf, E_sel_result, E_pc_src,
        output F_stall, D_stall, D_flush, E_flush, E_fwd_a, E_fwd_b,
        output M_rf_a3, M_we_rf, W_rf_a3, W_we_rf, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use stall, redirect flush and EX operand forwarding
module pipeline_hazard_unit #(
    parameter int         CNT_W    = 32,
    parameter logic [1:0] LOAD_SEL = 2'b01
) (
    input logic                    clk,
    input logic                    rst_n,
    pipeline_hazard_unit_if.slave  hz
);
    logic lu;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_a3,
        input logic       m_we,
        input logic [4:0] w_a3,
        input logic       w_we
    );
        // MEM is checked first so the youngest producer wins
        if (m_we && (m_a3 != 5'd0) && (m_a3 == src))
            return 2'b10;
        else if (w_we && (w_a3 != 5'd0) && (w_a3 == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        lu = (hz.E_sel_result == LOAD_SEL) && hz.E_we_rf && (hz.E_rf_a3 != 5'd0) &&
             ((hz.E_rf_a3 == hz.D_rs1) || (hz.E_rf_a3 == hz.D_rs2));
    end

    // A redirect discards the dependent ID instruction, so it overrides the stall
    always_comb begin
        hz.F_stall = 1'b0;
        hz.D_stall = 1'b0;
        hz.D_flush = 1'b0;
        hz.E_flush = 1'b0;
        if (hz.E_pc_src) begin
            hz.D_flush = 1'b1;
            hz.E_flush = 1'b1;
        end else if (lu) begin
            hz.F_stall = 1'b1;
            hz.D_stall = 1'b1;
            hz.E_flush = 1'b1;
        end
    end

    always_comb begin
        hz.E_fwd_a = fwd_sel(hz.E_rs1, hz.M_rf_a3, hz.M_we_rf, hz.W_rf_a3, hz.W_we_rf);
        hz.E_fwd_b = fwd_sel(hz.E_rs2, hz.M_rf_a3, hz.M_we_rf, hz.W_rf_a3, hz.W_we_rf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.M_rf_a3 <= 5'd0;
            hz.M_we_rf <= 1'b0;
            hz.W_rf_a3 <= 5'd0;
            hz.W_we_rf <= 1'b0;
        end else begin
            hz.M_rf_a3 <= hz.E_rf_a3;
            hz.M_we_rf <= hz.E_we_rf;
            hz.W_rf_a3 <= hz.M_rf_a3;
            hz.W_we_rf <= hz.M_we_rf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else begin
            if (lu && !hz.E_pc_src && (hz.stall_cnt != {CNT_W{1'b1}}))
                hz.stall_cnt <= hz.stall_cnt + CNT_W'(1);
            if (hz.E_pc_src && (hz.flush_cnt != {CNT_W{1'b1}}))
                hz.flush_cnt <= hz.flush_cnt + CNT_W'(1);
        end
    end
endmodule
